// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: Moore-decoded, registered control strobes.
// Optional CTRL_TRAP_EN sends illegal opcodes to a sticky TRAP state.
module multicycle_control #(
    parameter int MEM_LATENCY = 1,
    parameter int ALU_OP_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                alu_zero,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          mem_to_reg,
    output logic [5:0]          state_out,
    output logic                trap
);

    typedef enum logic [5:0] {
        S_RESET = 6'd0, S_FETCH = 6'd1, S_IR_LOAD = 6'd2, S_DECODE = 6'd3,
        S_EXEC_R = 6'd4, S_EXEC_I = 6'd5, S_ALU_WB = 6'd6, S_MEM_ADDR = 6'd7,
        S_MEM_READ = 6'd8, S_LOAD_WB = 6'd9, S_MEM_WRITE = 6'd10,
        S_BRANCH = 6'd11, S_JAL = 6'd12, S_TRAP = 6'd13
    } state_t;

    typedef struct packed {
        logic                pc_write;
        logic                ir_write;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                pc_src;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic [1:0]          mem_to_reg;
    } ctrl_t;

    localparam logic [ALU_OP_W-1:0] OP_ADD   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SUB   = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_FUNCT = ALU_OP_W'(3);
    localparam logic [3:0]          LAT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state, nxt;
    logic [3:0] cnt;
    ctrl_t      ctrl;
    logic       br_take;

    // Strobes for a given state; registered against the next state so they
    // line up with the state register without a combinational decode stage.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH, S_MEM_READ: c.mem_read = 1'b1;
            S_IR_LOAD: begin
                c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.alu_src_b = 2'b01; c.alu_op = OP_ADD;
            end
            S_DECODE: begin c.alu_src_b = 2'b11; c.alu_op = OP_ADD; end
            S_EXEC_R: begin c.alu_src_a = 1'b1; c.alu_op = OP_FUNCT; end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = OP_FUNCT;
            end
            S_ALU_WB: c.reg_write = 1'b1;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = OP_ADD;
            end
            S_LOAD_WB: begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
            S_MEM_WRITE: c.mem_write = 1'b1;
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = OP_SUB; c.pc_src = 1'b1;
            end
            S_JAL: begin
                c.pc_write = 1'b1; c.pc_src = 1'b1;
                c.reg_write = 1'b1; c.mem_to_reg = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_RESET:    nxt = S_FETCH;
            S_FETCH:    nxt = (cnt == LAT_LAST) ? S_IR_LOAD : S_FETCH;
            S_IR_LOAD:  nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    7'b0110011:             nxt = S_EXEC_R;
                    7'b0010011:             nxt = S_EXEC_I;
                    7'b0000011, 7'b0100011: nxt = S_MEM_ADDR;
                    7'b1100011:             nxt = S_BRANCH;
                    7'b1101111:             nxt = S_JAL;
`ifdef CTRL_TRAP_EN
                    default:                nxt = S_TRAP;
`else
                    default:                nxt = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R, S_EXEC_I: nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = (opcode == 7'b0000011) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: nxt = (cnt == LAT_LAST) ? S_LOAD_WB : S_MEM_READ;
`ifdef CTRL_TRAP_EN
            S_TRAP:     nxt = S_TRAP;
`endif
            default:    nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RESET;
            cnt   <= '0;
            ctrl  <= '0;
        end else begin
            state <= nxt;
            ctrl  <= decode(nxt);
            // Counter only advances while parked in a memory wait state.
            if (nxt == state && (state == S_FETCH || state == S_MEM_READ))
                cnt <= cnt + 4'd1;
            else
                cnt <= '0;
        end
    end

`ifdef CTRL_TRAP_EN
    logic trap_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) trap_q <= 1'b0;
        else     trap_q <= (nxt == S_TRAP);
    end
    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    // Branch resolution uses this cycle's ALU flag, so it bypasses the register.
    assign br_take = (state == S_BRANCH) &&
                     ((funct3 == 3'b000 && alu_zero) || (funct3 == 3'b001 && !alu_zero));

    assign pc_write   = ctrl.pc_write | br_take;
    assign ir_write   = ctrl.ir_write;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign reg_write  = ctrl.reg_write;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign state_out  = state;

endmodule
